// File: rtl/mem_bist_pkg.sv
// mem_bist_pkg: shared types and constants for the memory BIST block.
//   state_t     - March test state machine encoding
//   dir_t       - address stepping direction of a phase
//   pat_sel_t   - which background a cycle writes or expects (P or ~P)
//   DEFAULT_PATTERN - default background pattern P
// Helper functions map a state to its direction, pattern and access kind,
// so the FSM and the datapath share one table of March phase properties.
package mem_bist_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_W0      = 3'd1,
    S_R0W1_RD = 3'd2,
    S_R0W1_WR = 3'd3,
    S_R1W0_RD = 3'd4,
    S_R1W0_WR = 3'd5,
    S_R0_RD   = 3'd6,
    S_DONE    = 3'd7
  } state_t;

  typedef enum logic {
    DIR_UP = 1'b0,
    DIR_DN = 1'b1
  } dir_t;

  typedef enum logic {
    PAT_TRUE = 1'b0,  // background P
    PAT_INV  = 1'b1   // complement ~P
  } pat_sel_t;

  localparam logic [7:0] DEFAULT_PATTERN = 8'h55;
  localparam int         ERR_W           = 8;
  localparam logic [ERR_W-1:0] ERR_MAX   = '1;

  // Only the R1W0 element walks downwards.
  function automatic dir_t state_dir(input state_t s);
    return ((s == S_R1W0_RD) || (s == S_R1W0_WR)) ? DIR_DN : DIR_UP;
  endfunction

  // R0W1 writes ~P and R1W0 expects ~P; every other access uses P.
  function automatic pat_sel_t state_pat(input state_t s);
    return ((s == S_R0W1_WR) || (s == S_R1W0_RD)) ? PAT_INV : PAT_TRUE;
  endfunction

  function automatic logic is_write(input state_t s);
    return (s == S_W0) || (s == S_R0W1_WR) || (s == S_R1W0_WR);
  endfunction

  function automatic logic is_read(input state_t s);
    return (s == S_R0W1_RD) || (s == S_R1W0_RD) || (s == S_R0_RD);
  endfunction

endpackage

// File: rtl/mem_bist_if.sv
// mem_bist_if: the processor-side data memory port (rw_addr / r / w / w_en).
//   master - the initiator (mips core or mem_bist): drives address, write
//            data and write enable, receives combinational read data.
//   slave  - the memory: returns r for rw_addr in the same cycle and
//            writes w at the rising edge while w_en is high.
interface mem_bist_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] rw_addr;
  logic [DATA_W-1:0] r;
  logic [DATA_W-1:0] w;
  logic              w_en;

  modport master (
    output rw_addr,
    output w,
    output w_en,
    input  r
  );

  modport slave (
    input  rw_addr,
    input  w,
    input  w_en,
    output r
  );
endinterface

// File: rtl/mem_bist_addr_gen.sv
// mem_bist_addr_gen: loadable up/down address counter for the March walk.
//   clk, rst   - clock, asynchronous active-high reset
//   load       - load load_val (has priority over step)
//   load_val   - start address of the next phase
//   step       - advance one address in direction dir
//   dir        - DIR_UP increments, DIR_DN decrements
//   limit      - last address of the current phase
//   addr       - current address (registered)
//   at_end     - addr equals limit
// The end of a phase is found by equality, and a step requested at the
// limit is dropped, so 0xFF never rolls to 0x00 nor 0x00 to 0xFF.
module mem_bist_addr_gen
  import mem_bist_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              step,
  input  dir_t              dir,
  input  logic [ADDR_W-1:0] limit,
  output logic [ADDR_W-1:0] addr,
  output logic              at_end
);

  logic [ADDR_W-1:0] addr_q, addr_d;

  assign at_end = (addr_q == limit);
  assign addr   = addr_q;

  // NOTE: every combinational output gets a default before any branch;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    addr_d = addr_q;
    if (load) begin
      addr_d = load_val;
    end else if (step && !at_end) begin
      addr_d = (dir == DIR_UP) ? addr_q + ADDR_W'(1) : addr_q - ADDR_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments only, so every flop
  // samples the pre-edge value of its inputs regardless of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

endmodule

// File: rtl/mem_bist.sv
// mem_bist: March test initiator for the 8-bit external data memory port.
// Sequence: W0(up, write P), R0W1(up, read P / write ~P),
//           R1W0(down, read ~P / write P), R0(up, read P).
//   clk, rst        - clock, asynchronous active-high reset
//   start           - begin a test; sampled only in IDLE
//   base_addr       - first address of the window, sampled with start
//   last_addr       - last address of the window (inclusive), sampled with start
//   mem             - memory port (rw_addr, r, w, w_en), master side
//   busy            - test in progress
//   done            - one-cycle pulse when the test completes
//   pass            - no mismatch seen; valid from done until next start
//   err_count       - read mismatches, saturating at 255
//   first_err_addr  - address of the first mismatch, 0 if none
// All outputs are registers. The memory port registers are loaded from the
// next state, so an access appears in the cycle the FSM is in that state.
module mem_bist
  import mem_bist_pkg::*;
#(
  parameter int                ADDR_W  = 8,
  parameter int                DATA_W  = 8,
  parameter logic [DATA_W-1:0] PATTERN = DATA_W'(DEFAULT_PATTERN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] last_addr,
  mem_bist_if.master        mem,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic [ADDR_W-1:0] first_err_addr
);

  function automatic logic [DATA_W-1:0] pat_value(input pat_sel_t sel);
    return (sel == PAT_INV) ? ~PATTERN : PATTERN;
  endfunction

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic [DATA_W-1:0] w_q, w_d;
  logic              w_en_q, w_en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [ERR_W-1:0]  err_count_q, err_count_d;
  logic [ADDR_W-1:0] first_err_q, first_err_d;

  logic              start_acc;
  logic              ag_load;
  logic [ADDR_W-1:0] ag_load_val;
  logic              ag_step;
  dir_t              ag_dir;
  logic [ADDR_W-1:0] ag_limit;
  logic [ADDR_W-1:0] addr;
  logic              at_end;
  logic [DATA_W-1:0] exp_data;
  logic              mismatch;

  // Descending phases stop at the base, ascending ones at the last address.
  assign ag_dir   = state_dir(state_q);
  assign ag_limit = (ag_dir == DIR_DN) ? base_q : last_q;

  mem_bist_addr_gen #(
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .load     (ag_load),
    .load_val (ag_load_val),
    .step     (ag_step),
    .dir      (ag_dir),
    .limit    (ag_limit),
    .addr     (addr),
    .at_end   (at_end)
  );

  // Next-state logic and address counter control.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    last_d      = last_q;
    start_acc   = 1'b0;
    ag_load     = 1'b0;
    ag_load_val = base_q;
    ag_step     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          base_d    = base_addr;
          last_d    = last_addr;
          if (base_addr > last_addr) begin
            // Empty window: report a clean pass without touching memory.
            state_d = S_DONE;
          end else begin
            state_d     = S_W0;
            ag_load     = 1'b1;
            ag_load_val = base_addr;
          end
        end
      end
      S_W0: begin
        if (at_end) begin
          state_d     = S_R0W1_RD;
          ag_load     = 1'b1;
          ag_load_val = base_q;
        end else begin
          ag_step = 1'b1;
        end
      end
      S_R0W1_RD: state_d = S_R0W1_WR;
      S_R0W1_WR: begin
        if (at_end) begin
          state_d     = S_R1W0_RD;
          ag_load     = 1'b1;
          ag_load_val = last_q;
        end else begin
          state_d = S_R0W1_RD;
          ag_step = 1'b1;
        end
      end
      S_R1W0_RD: state_d = S_R1W0_WR;
      S_R1W0_WR: begin
        if (at_end) begin
          state_d     = S_R0_RD;
          ag_load     = 1'b1;
          ag_load_val = base_q;
        end else begin
          state_d = S_R1W0_RD;
          ag_step = 1'b1;
        end
      end
      S_R0_RD: begin
        if (at_end) begin
          state_d = S_DONE;
        end else begin
          ag_step = 1'b1;
        end
      end
      // start is deliberately not looked at here; it is seen again in IDLE.
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Comparator, result registers and memory port outputs.
  assign exp_data = pat_value(state_pat(state_q));
  assign mismatch = is_read(state_q) && (mem.r != exp_data);

  always_comb begin
    err_count_d = err_count_q;
    first_err_d = first_err_q;
    pass_d      = pass_q;

    if (start_acc) begin
      err_count_d = '0;
      first_err_d = '0;
      pass_d      = 1'b0;
    end else if (mismatch) begin
      if (err_count_q != ERR_MAX) begin
        err_count_d = err_count_q + ERR_W'(1);
      end
      // A zero count means this is the first mismatch since start.
      if (err_count_q == '0) begin
        first_err_d = addr;
      end
    end

    // Uses err_count_d so the final R0 read is included in the verdict.
    if (state_d == S_DONE) begin
      pass_d = (err_count_d == '0);
    end

    w_en_d = is_write(state_d);
    w_d    = is_write(state_d) ? pat_value(state_pat(state_d)) : w_q;
    done_d = (state_d == S_DONE);
    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
  end

  // NOTE: the asynchronous reset clears w_en at once, so a reset mid-run
  // can never leave a write pending on the memory.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      last_q      <= '0;
      w_q         <= '0;
      w_en_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_count_q <= '0;
      first_err_q <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      last_q      <= last_d;
      w_q         <= w_d;
      w_en_q      <= w_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_count_q <= err_count_d;
      first_err_q <= first_err_d;
    end
  end

  assign mem.rw_addr    = addr;
  assign mem.w          = w_q;
  assign mem.w_en       = w_en_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_count_q;
  assign first_err_addr = first_err_q;

endmodule

// File: tb/tb_mem_bist.sv
// tb_mem_bist: self-checking bench for mem_bist.
// A behavioural memory (with optional stuck-at bits on the read path) is
// attached to the port. For each run the bench lists the March operations
// from the algorithm itself, predicts the per-cycle port activity and the
// verdict, and compares cycle by cycle. Directed runs cover the boundary
// windows, reset mid-run, held start and saturation; random runs follow.
module tb_mem_bist;

  localparam logic [7:0] P = 8'h55;

  typedef struct {
    bit         we;
    logic [7:0] addr;
    logic [7:0] data;  // write data, or expected read data
  } op_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] base_addr;
  logic [7:0] last_addr;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] err_count;
  logic [7:0] first_err_addr;

  int n_checks = 0;
  int n_bad    = 0;

  mem_bist_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  mem_bist #(
    .ADDR_W  (8),
    .DATA_W  (8),
    .PATTERN (P)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .base_addr      (base_addr),
    .last_addr      (last_addr),
    .mem            (bus.master),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_count      (err_count),
    .first_err_addr (first_err_addr)
  );

  always #5 clk = ~clk;

  // Memory model with optional stuck-at faults on the read path.
  logic [7:0] mem [256];
  logic       fault_on  = 1'b0;
  logic       fault_all = 1'b0;
  logic [7:0] fault_addr = 8'h00;
  logic [7:0] sa0 = 8'h00;
  logic [7:0] sa1 = 8'h00;

  function automatic logic [7:0] read_fault(input logic [7:0] v, input logic [7:0] a);
    if (fault_on && (fault_all || a == fault_addr)) return (v | sa1) & ~sa0;
    return v;
  endfunction

  always @(posedge clk) if (bus.w_en) mem[bus.rw_addr] <= bus.w;
  assign bus.r = read_fault(mem[bus.rw_addr], bus.rw_addr);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic start_run(input logic [7:0] b, input logic [7:0] l);
    @(negedge clk);
    base_addr = b;
    last_addr = l;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    // Window inputs must have been captured with start.
    base_addr = 8'($urandom);
    last_addr = 8'($urandom);
  endtask

  // Called just after the edge that accepted start. Ends at mid-DONE cycle.
  task automatic observe_run(input int b, input int l, input string tag);
    op_t        ops[$];
    logic [7:0] model [256];
    logic [7:0] got;
    int         errs = 0;
    logic [7:0] first = 8'h00;
    logic [7:0] below, above;
    int         bad_cells = 0;

    if (b <= l) begin
      for (int a = b; a <= l; a++) ops.push_back('{we: 1'b1, addr: 8'(a), data: P});
      for (int a = b; a <= l; a++) begin
        ops.push_back('{we: 1'b0, addr: 8'(a), data: P});
        ops.push_back('{we: 1'b1, addr: 8'(a), data: ~P});
      end
      for (int a = l; a >= b; a--) begin
        ops.push_back('{we: 1'b0, addr: 8'(a), data: ~P});
        ops.push_back('{we: 1'b1, addr: 8'(a), data: P});
      end
      for (int a = b; a <= l; a++) ops.push_back('{we: 1'b0, addr: 8'(a), data: P});
    end

    foreach (ops[i]) begin
      if (ops[i].we) begin
        model[ops[i].addr] = ops[i].data;
      end else begin
        got = read_fault(model[ops[i].addr], ops[i].addr);
        if (got != ops[i].data) begin
          if (errs == 0) first = ops[i].addr;
          errs++;
        end
      end
    end

    below = (b > 0)   ? mem[8'(b - 1)] : 8'h00;
    above = (l < 255) ? mem[8'(l + 1)] : 8'h00;

    foreach (ops[i]) begin
      @(negedge clk);
      if (i == 0) check({tag, " clr"}, {pass, err_count, first_err_addr}, 64'h0);
      check($sformatf("%s op%0d", tag, i),
            {busy, done, bus.w_en, bus.rw_addr, bus.w_en ? bus.w : 8'h00},
            {1'b1, 1'b0, ops[i].we, ops[i].addr, ops[i].we ? ops[i].data : 8'h00});
    end

    @(negedge clk);
    check({tag, " done"}, {busy, done, bus.w_en}, 3'b010);
    check({tag, " pass"}, pass, errs == 0);
    check({tag, " errs"}, err_count, (errs > 255) ? 255 : errs);
    check({tag, " first"}, first_err_addr, first);

    if (b <= l) begin
      for (int a = b; a <= l; a++) if (mem[a] !== P) bad_cells++;
      check({tag, " cells"}, bad_cells, 0);
      if (b > 0)   check({tag, " below"}, mem[8'(b - 1)], below);
      if (l < 255) check({tag, " above"}, mem[8'(l + 1)], above);
    end
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    base_addr = 8'h00;
    last_addr = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset", {bus.rw_addr, bus.w, bus.w_en, busy, done, pass, err_count, first_err_addr}, 64'h0);
    rst = 1'b0;

    // Fault-free small window.
    start_run(8'h10, 8'h13);
    observe_run(8'h10, 8'h13, "clean");
    check("clean pass", pass, 1'b1);

    // Bit0 stuck-at-0 at 0x12.
    fault_on = 1'b1; fault_all = 1'b0; fault_addr = 8'h12; sa0 = 8'h01; sa1 = 8'h00;
    start_run(8'h10, 8'h13);
    observe_run(8'h10, 8'h13, "sa0");
    check("sa0 errs const", err_count, 8'd2);
    check("sa0 first const", first_err_addr, 8'h12);
    check("sa0 pass const", pass, 1'b0);
    fault_on = 1'b0;

    // Top of the address space.
    start_run(8'hFE, 8'hFF);
    observe_run(8'hFE, 8'hFF, "top");

    // Empty window.
    start_run(8'h20, 8'h1F);
    observe_run(8'h20, 8'h1F, "empty");

    // Reset during the first R0W1_WR, after one mismatch was counted.
    fault_on = 1'b1; fault_addr = 8'h30; sa0 = 8'h01; sa1 = 8'h00;
    start_run(8'h30, 8'h33);
    repeat (4 + 2) @(negedge clk);
    check("pre-rst w_en", bus.w_en, 1'b1);
    check("pre-rst errs", err_count, 8'd1);
    #1 rst = 1'b1;
    #1;
    check("async rst", {bus.rw_addr, bus.w, bus.w_en, busy, done, pass, err_count, first_err_addr}, 64'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    fault_on = 1'b0;
    start_run(8'h30, 8'h33);
    observe_run(8'h30, 8'h33, "post-rst");

    // start held high: no restart while busy or in DONE, restart from IDLE.
    @(negedge clk);
    base_addr = 8'h40; last_addr = 8'h42; start = 1'b1;
    @(posedge clk);
    observe_run(8'h40, 8'h42, "held1");
    @(negedge clk);
    check("held idle gap", {busy, done}, 2'b00);
    fault_on = 1'b1; fault_addr = 8'h41; sa0 = 8'h01; sa1 = 8'h00;
    @(posedge clk);
    #1 start = 1'b0;
    observe_run(8'h40, 8'h42, "held2");
    fault_on = 1'b0;
    start_run(8'h40, 8'h42);
    observe_run(8'h40, 8'h42, "pulse");

    // Every read fails: the count saturates; base=0 must not wrap.
    fault_on = 1'b1; fault_all = 1'b1; sa0 = 8'hFF; sa1 = 8'h00;
    start_run(8'h00, 8'h9F);
    observe_run(8'h00, 8'h9F, "sat");
    check("sat const", err_count, 8'd255);
    fault_on = 1'b0; fault_all = 1'b0;

    // Randomized windows and faults.
    for (int it = 0; it < 12; it++) begin
      int b, l, kind;
      b = $urandom_range(0, 255);
      l = b + $urandom_range(0, 11);
      if (l > 255) l = 255;
      if ($urandom_range(0, 5) == 0 && b > 0) l = b - 1;
      kind = $urandom_range(0, 2);
      fault_on   = (kind != 0);
      fault_addr = 8'($urandom_range(b, (l >= b) ? l : b));
      sa0        = (kind == 1) ? 8'($urandom) : 8'h00;
      sa1        = (kind == 2) ? 8'($urandom) : 8'h00;
      start_run(8'(b), 8'(l));
      observe_run(b, l, $sformatf("rnd%0d", it));
    end
    fault_on = 1'b0;

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
